// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IF/LS requesters, the arbiter and the memory wrapper.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);
   localparam int unsigned MASK_W = 8;

   // Instruction fetch port
   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_resp_valid;
   logic [DATA_W-1:0] if_rdata;

   // Load/store port
   logic              ls_req_valid;
   logic              ls_req_ready;
   logic [ADDR_W-1:0] ls_addr;
   logic              ls_wen;
   logic [DATA_W-1:0] ls_wdata;
   logic [MASK_W-1:0] ls_wmask;
   logic              ls_resp_valid;
   logic [DATA_W-1:0] ls_rdata;

   // Shared memory port
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wen;
   logic [MASK_W-1:0] mem_wmask;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side: serves both requesters and drives the memory port
   modport slave (
      input  if_req_valid, if_addr,
      output if_req_ready, if_resp_valid, if_rdata,
      input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
      output ls_req_ready, ls_resp_valid, ls_rdata,
      output mem_req, mem_addr, mem_wdata, mem_wen, mem_wmask,
      input  mem_rdata
   );

   // Environment side: requesters plus the memory wrapper
   modport master (
      output if_req_valid, if_addr,
      input  if_req_ready, if_resp_valid, if_rdata,
      output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
      input  ls_req_ready, ls_resp_valid, ls_rdata,
      input  mem_req, mem_addr, mem_wdata, mem_wen, mem_wmask,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between fetch and load/store.
// MEM_LAT must be at least 1.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic   clk,
   input  logic   rst,
   mem_arbiter_if.slave bus
);
   localparam int unsigned MASK_W = 8;
   localparam int unsigned CNT_W  = ($clog2(MEM_LAT + 1) < 1) ? 1 : $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
   typedef enum logic       {G_IF = 1'b0, G_LS = 1'b1}         grant_e;

   state_e            state_q,         state_d;
   logic [CNT_W-1:0]  cnt_q,           cnt_d;
   grant_e            last_grant_q,    last_grant_d;
   grant_e            grant_q,         grant_d;
   logic              mem_req_q,       mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q,      mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q,     mem_wdata_d;
   logic              mem_wen_q,       mem_wen_d;
   logic [MASK_W-1:0] mem_wmask_q,     mem_wmask_d;
   logic              if_resp_valid_q, if_resp_valid_d;
   logic [DATA_W-1:0] if_rdata_q,      if_rdata_d;
   logic              ls_resp_valid_q, ls_resp_valid_d;
   logic [DATA_W-1:0] ls_rdata_q,      ls_rdata_d;

   // Ready must follow the live valids so a dropped request in IDLE is never accepted.
   logic if_ready_c, ls_ready_c;
   logic if_wins_c,  ls_wins_c;
   logic [DATA_W-1:0] cap_data_c;

   // Arbitration: a lone valid wins; on a tie the requester not granted last time wins.
   always_comb begin
      if_wins_c  = bus.if_req_valid & (~bus.ls_req_valid | (last_grant_q == G_LS));
      ls_wins_c  = bus.ls_req_valid & ~if_wins_c;
      cap_data_c = mem_wen_q ? '0 : bus.mem_rdata;
   end

   // Next-state, latching and response generation.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      last_grant_d    = last_grant_q;
      grant_d         = grant_q;
      mem_req_d       = 1'b0;
      mem_addr_d      = mem_addr_q;
      mem_wdata_d     = mem_wdata_q;
      mem_wen_d       = mem_wen_q;
      mem_wmask_d     = mem_wmask_q;
      if_resp_valid_d = 1'b0;
      if_rdata_d      = if_rdata_q;
      ls_resp_valid_d = 1'b0;
      ls_rdata_d      = ls_rdata_q;
      if_ready_c      = 1'b0;
      ls_ready_c      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if_ready_c = if_wins_c;
            ls_ready_c = ls_wins_c;
            if (if_wins_c) begin
               state_d      = S_ISSUE;
               grant_d      = G_IF;
               last_grant_d = G_IF;
               mem_req_d    = 1'b1;
               mem_addr_d   = bus.if_addr;
               mem_wdata_d  = '0;
               mem_wen_d    = 1'b0;
               mem_wmask_d  = '0;
            end else if (ls_wins_c) begin
               state_d      = S_ISSUE;
               grant_d      = G_LS;
               last_grant_d = G_LS;
               mem_req_d    = 1'b1;
               mem_addr_d   = bus.ls_addr;
               mem_wdata_d  = bus.ls_wdata;
               mem_wen_d    = bus.ls_wen;
               mem_wmask_d  = bus.ls_wmask;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_W'(MEM_LAT);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_RESP;
               if (grant_q == G_IF) begin
                  if_rdata_d      = cap_data_c;
                  if_resp_valid_d = 1'b1;
               end else begin
                  ls_rdata_d      = cap_data_c;
                  ls_resp_valid_d = 1'b1;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         last_grant_q    <= G_LS;
         grant_q         <= G_IF;
         mem_req_q       <= 1'b0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         mem_wen_q       <= 1'b0;
         mem_wmask_q     <= '0;
         if_resp_valid_q <= 1'b0;
         if_rdata_q      <= '0;
         ls_resp_valid_q <= 1'b0;
         ls_rdata_q      <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         last_grant_q    <= last_grant_d;
         grant_q         <= grant_d;
         mem_req_q       <= mem_req_d;
         mem_addr_q      <= mem_addr_d;
         mem_wdata_q     <= mem_wdata_d;
         mem_wen_q       <= mem_wen_d;
         mem_wmask_q     <= mem_wmask_d;
         if_resp_valid_q <= if_resp_valid_d;
         if_rdata_q      <= if_rdata_d;
         ls_resp_valid_q <= ls_resp_valid_d;
         ls_rdata_q      <= ls_rdata_d;
      end
   end

   // Port drive
   assign bus.if_req_ready  = if_ready_c;
   assign bus.ls_req_ready  = ls_ready_c;
   assign bus.if_resp_valid = if_resp_valid_q;
   assign bus.if_rdata      = if_rdata_q;
   assign bus.ls_resp_valid = ls_resp_valid_q;
   assign bus.ls_rdata      = ls_rdata_q;
   assign bus.mem_req       = mem_req_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_wdata     = mem_wdata_q;
   assign bus.mem_wen       = mem_wen_q;
   assign bus.mem_wmask     = mem_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LAT=1 and MEM_LAT=4 instances.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();
   mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b4 ();

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Contention event log
   int          ev_cyc [8];
   logic        ev_ls  [8];
   logic [63:0] ev_dat [8];
   int          nev;
   int          mreq_cnt;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      b1.if_req_valid = 0; b1.if_addr = '0;
      b1.ls_req_valid = 0; b1.ls_addr = '0; b1.ls_wen = 0; b1.ls_wdata = '0; b1.ls_wmask = '0;
      b1.mem_rdata = '0;
      b4.if_req_valid = 0; b4.if_addr = '0;
      b4.ls_req_valid = 0; b4.ls_addr = '0; b4.ls_wen = 0; b4.ls_wdata = '0; b4.ls_wmask = '0;
      b4.mem_rdata = '0;
      for (int i = 0; i < 8; i++) begin ev_cyc[i] = 0; ev_ls[i] = 0; ev_dat[i] = '0; end
      nev = 0;
      #2;
      // Reset state
      chk("rst_mem_req",  64'(b1.mem_req), 64'd0);
      chk("rst_mem_addr", b1.mem_addr, 64'd0);
      chk("rst_mem_wen",  64'(b1.mem_wen), 64'd0);
      chk("rst_if_resp",  64'(b1.if_resp_valid), 64'd0);
      chk("rst_ls_rdata", b1.ls_rdata, 64'd0);
      cyc(); cyc();
      rst = 1'b1;

      // Single IF read, MEM_LAT=1
      cyc(); b1.if_req_valid = 1; b1.if_addr = 64'h8000_0000; #1;
      chk("ifr_if_ready", 64'(b1.if_req_ready), 64'd1);
      chk("ifr_ls_ready", 64'(b1.ls_req_ready), 64'd0);
      chk("ifr_T_mem_req", 64'(b1.mem_req), 64'd0);
      cyc(); b1.if_req_valid = 0; b1.if_addr = '1; #1;
      chk("ifr_T1_mem_req", 64'(b1.mem_req), 64'd1);
      chk("ifr_T1_mem_addr", b1.mem_addr, 64'h8000_0000);
      chk("ifr_T1_mem_wen", 64'(b1.mem_wen), 64'd0);
      cyc(); b1.mem_rdata = 64'h0000_0013; #1;
      chk("ifr_T2_mem_req", 64'(b1.mem_req), 64'd0);
      chk("ifr_T2_resp", 64'(b1.if_resp_valid), 64'd0);
      cyc(); b1.mem_rdata = 64'hdead; #1;
      chk("ifr_T3_resp", 64'(b1.if_resp_valid), 64'd1);
      chk("ifr_T3_rdata", b1.if_rdata, 64'h13);
      chk("ifr_T3_ls_resp", 64'(b1.ls_resp_valid), 64'd0);
      chk("ifr_T3_ls_rdata", b1.ls_rdata, 64'd0);
      chk("ifr_T3_mem_addr", b1.mem_addr, 64'h8000_0000);
      cyc(); #1;
      chk("ifr_T4_resp", 64'(b1.if_resp_valid), 64'd0);

      // LS write
      cyc(); b1.ls_req_valid = 1; b1.ls_wen = 1; b1.ls_addr = 64'h8000_1000;
      b1.ls_wdata = 64'hdead_beef; b1.ls_wmask = 8'h0f; #1;
      chk("lsw_ls_ready", 64'(b1.ls_req_ready), 64'd1);
      chk("lsw_if_ready", 64'(b1.if_req_ready), 64'd0);
      cyc(); b1.ls_req_valid = 0; b1.ls_wen = 0; b1.ls_wdata = '0; b1.ls_wmask = 8'hff;
      b1.mem_rdata = 64'h5555; #1;
      chk("lsw_T1_mem_req", 64'(b1.mem_req), 64'd1);
      chk("lsw_T1_mem_wen", 64'(b1.mem_wen), 64'd1);
      chk("lsw_T1_mem_wmask", 64'(b1.mem_wmask), 64'h0f);
      chk("lsw_T1_mem_wdata", b1.mem_wdata, 64'hdead_beef);
      chk("lsw_T1_mem_addr", b1.mem_addr, 64'h8000_1000);
      cyc(); #1;
      chk("lsw_T2_mem_wen", 64'(b1.mem_wen), 64'd1);
      chk("lsw_T2_mem_wmask", 64'(b1.mem_wmask), 64'h0f);
      chk("lsw_T2_ls_resp", 64'(b1.ls_resp_valid), 64'd0);
      cyc(); #1;
      chk("lsw_T3_ls_resp", 64'(b1.ls_resp_valid), 64'd1);
      chk("lsw_T3_ls_rdata", b1.ls_rdata, 64'd0);
      chk("lsw_T3_mem_wen", 64'(b1.mem_wen), 64'd1);
      chk("lsw_T3_mem_wmask", 64'(b1.mem_wmask), 64'h0f);
      chk("lsw_T3_if_resp", 64'(b1.if_resp_valid), 64'd0);
      cyc(); #1;
      chk("lsw_T4_ls_resp", 64'(b1.ls_resp_valid), 64'd0);

      // Withdrawn LS request while busy
      cyc(); b1.if_req_valid = 1; b1.if_addr = 64'h8000_0004; #1;
      chk("wd_if_ready", 64'(b1.if_req_ready), 64'd1);
      cyc(); b1.if_req_valid = 0; b1.ls_req_valid = 1; b1.ls_wen = 0; #1;
      chk("wd_T1_ls_ready", 64'(b1.ls_req_ready), 64'd0);
      cyc(); b1.ls_req_valid = 0; #1;
      chk("wd_T2_ls_ready", 64'(b1.ls_req_ready), 64'd0);
      mreq_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(); #1;
         chk("wd_ls_ready", 64'(b1.ls_req_ready), 64'd0);
         chk("wd_ls_resp", 64'(b1.ls_resp_valid), 64'd0);
         if (b1.mem_req) mreq_cnt++;
      end
      chk("wd_no_issue", 64'(mreq_cnt), 64'd0);

      // Reset during WAIT
      cyc(); b1.if_req_valid = 1; b1.if_addr = 64'h8000_0008; #1;
      chk("rmo_if_ready", 64'(b1.if_req_ready), 64'd1);
      cyc(); b1.if_req_valid = 0; #1;
      chk("rmo_mem_req", 64'(b1.mem_req), 64'd1);
      cyc(); b1.mem_rdata = 64'h77; rst = 1'b0; #1;
      chk("rmo_mem_addr", b1.mem_addr, 64'd0);
      chk("rmo_mem_req0", 64'(b1.mem_req), 64'd0);
      chk("rmo_if_rdata", b1.if_rdata, 64'd0);
      chk("rmo_if_resp", 64'(b1.if_resp_valid), 64'd0);
      cyc(); #1;
      chk("rmo_no_resp", 64'(b1.if_resp_valid), 64'd0);
      cyc(); rst = 1'b1;
      b1.if_req_valid = 1; b1.if_addr = 64'h8000_0010;
      b1.ls_req_valid = 1; b1.ls_addr = 64'h8000_2000; b1.ls_wen = 0; #1;
      chk("rmo_tie_if", 64'(b1.if_req_ready), 64'd1);
      chk("rmo_tie_ls", 64'(b1.ls_req_ready), 64'd0);
      cyc(); b1.if_req_valid = 0; b1.ls_req_valid = 0; #1;
      chk("rmo_T1_mem_addr", b1.mem_addr, 64'h8000_0010);
      cyc(); b1.mem_rdata = 64'h99; #1;
      cyc(); #1;
      chk("rmo_T3_resp", 64'(b1.if_resp_valid), 64'd1);
      chk("rmo_T3_rdata", b1.if_rdata, 64'h99);

      // Contention from reset: strict alternation, responses MEM_LAT+3 apart
      cyc(); rst = 1'b0;
      cyc(); rst = 1'b1;
      b1.if_req_valid = 1; b1.if_addr = 64'h8000_0100;
      b1.ls_req_valid = 1; b1.ls_addr = 64'h8000_0200; b1.ls_wen = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         b1.mem_rdata = b1.mem_addr ^ 64'hF0F0;
         if (nev < 8 && b1.if_resp_valid) begin
            ev_cyc[nev] = c; ev_ls[nev] = 1'b0; ev_dat[nev] = b1.if_rdata; nev++;
         end
         if (nev < 8 && b1.ls_resp_valid) begin
            ev_cyc[nev] = c; ev_ls[nev] = 1'b1; ev_dat[nev] = b1.ls_rdata; nev++;
         end
         cyc();
      end
      b1.if_req_valid = 0; b1.ls_req_valid = 0;
      chk("cont_nev", 64'(nev >= 4), 64'd1);
      chk("cont_first_cyc", 64'(ev_cyc[0]), 64'd3);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("cont_who%0d", k), 64'(ev_ls[k]), 64'(k % 2));
         chk($sformatf("cont_dat%0d", k), ev_dat[k],
             ((k % 2) == 0) ? (64'h8000_0100 ^ 64'hF0F0) : (64'h8000_0200 ^ 64'hF0F0));
      end
      for (int k = 1; k < 4; k++)
         chk($sformatf("cont_gap%0d", k), 64'(ev_cyc[k] - ev_cyc[k-1]), 64'd4);

      // MEM_LAT=4 instance
      cyc(); b4.if_req_valid = 1; b4.if_addr = 64'h8000_3000; #1;
      chk("l4_if_ready", 64'(b4.if_req_ready), 64'd1);
      cyc(); b4.if_req_valid = 0; b4.if_addr = '0; b4.mem_rdata = 64'hAAAA; #1;
      chk("l4_T1_mem_req", 64'(b4.mem_req), 64'd1);
      for (int w = 0; w < 4; w++) begin
         cyc(); b4.mem_rdata = (w == 3) ? 64'h1234 : (64'hAAAB + 64'(w)); #1;
         chk($sformatf("l4_wait%0d_addr", w), b4.mem_addr, 64'h8000_3000);
         chk($sformatf("l4_wait%0d_resp", w), 64'(b4.if_resp_valid), 64'd0);
         chk($sformatf("l4_wait%0d_req", w), 64'(b4.mem_req), 64'd0);
      end
      cyc(); b4.mem_rdata = 64'hBBBB; #1;
      chk("l4_T6_resp", 64'(b4.if_resp_valid), 64'd1);
      chk("l4_T6_rdata", b4.if_rdata, 64'h1234);
      chk("l4_T6_ls_resp", 64'(b4.ls_resp_valid), 64'd0);
      cyc(); #1;
      chk("l4_T7_resp", 64'(b4.if_resp_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
